reverb_template_pio_gen: RTL and testbench

REVERB_TEMPLATE_PIO_GEN -- requirements
Module: reverb_template_pio_gen

---
 rtl/reverb_template_pio_gen.sv | 99 +++++++++
 tb/tb_reverb_template_pio_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reverb_template_pio_gen.sv
// Avalon-MM parallel I/O port: registered outputs with set/clear aliases,
// synchronized inputs with edge capture and a maskable level interrupt.
module reverb_template_pio_gen #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  typedef enum logic [2:0] {
    A_DATA    = 3'd0,
    A_OUTSET  = 3'd1,
    A_OUTCLR  = 3'd2,
    A_IRQMASK = 3'd3,
    A_EDGECAP = 3'd4
  } reg_addr_t;

  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_cap;
  logic [DATA_WIDTH-1:0] sync1, sync2, prev;
  logic [DATA_WIDTH-1:0] edge_evt;
  logic [DATA_WIDTH-1:0] clr_mask;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd;
  logic                  wr;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[DATA_WIDTH-1:0];

  always_comb begin
    edge_evt = '0;
    if (EDGE_TYPE == 0)      edge_evt = sync2 & ~prev;
    else if (EDGE_TYPE == 1) edge_evt = ~sync2 & prev;
    else                     edge_evt = sync2 ^ prev;
  end

  always_comb begin
    clr_mask = '0;
    if (wr && address == A_EDGECAP) clr_mask = wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= RESET_VALUE[DATA_WIDTH-1:0];
      irq_mask <= '0;
      edge_cap <= '0;
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
      // a new edge overrides a simultaneous write-1-clear on the same bit
      edge_cap <= (edge_cap & ~clr_mask) | edge_evt;
      if (wr) begin
        case (address)
          A_DATA:    data_out <= wd;
          A_OUTSET:  data_out <= data_out | wd;
          A_OUTCLR:  data_out <= data_out & ~wd;
          A_IRQMASK: irq_mask <= wd;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    rd = '0;
    case (address)
      A_DATA:    rd = sync2;
      A_OUTSET:  rd = data_out;
      A_OUTCLR:  rd = data_out;
      A_IRQMASK: rd = irq_mask;
      A_EDGECAP: rd = edge_cap;
      default:   rd = '0;
    endcase
  end

  always_comb begin
    readdata = '0;
    readdata[DATA_WIDTH-1:0] = rd;
  end

  assign out_port = data_out;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_reverb_template_pio_gen.sv
// Directed bench for the PIO block across several parameterizations
// sharing one Avalon bus with per-instance chip selects.
module tb_reverb_template_pio_gen;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic [3:0]  cs;
  logic        write_n;
  logic [31:0] writedata;

  logic [7:0]  in0, in2;
  logic [31:0] in32;
  logic [0:0]  in1;
  logic [31:0] rd0, rd2, rd32, rd1;
  logic [7:0]  out0, out2;
  logic [31:0] out32;
  logic [0:0]  out1;
  logic        irq0, irq2, irq32, irq1;

  int unsigned total;
  int unsigned passed;

  reverb_template_pio_gen #(.DATA_WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in0), .out_port(out0), .irq(irq0));

  reverb_template_pio_gen #(.DATA_WIDTH(8), .RESET_VALUE(32'h0), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]), .write_n(write_n),
    .writedata(writedata), .readdata(rd2), .in_port(in2), .out_port(out2), .irq(irq2));

  reverb_template_pio_gen #(.DATA_WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(0)) u32 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]), .write_n(write_n),
    .writedata(writedata), .readdata(rd32), .in_port(in32), .out_port(out32), .irq(irq32));

  reverb_template_pio_gen #(.DATA_WIDTH(1), .RESET_VALUE(32'h0), .EDGE_TYPE(0)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[3]), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .in_port(in1), .out_port(out1), .irq(irq1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; the write is sampled by the following posedge and
  // the task returns at the next negedge.
  task automatic wr(input logic [3:0] sel, input logic [2:0] a, input logic [31:0] d);
    cs        = sel;
    address   = a;
    write_n   = 1'b0;
    writedata = d;
    @(negedge clk);
    cs        = '0;
    write_n   = 1'b1;
    writedata = '0;
  endtask

  task automatic rd(input logic [2:0] a);
    cs      = '0;
    write_n = 1'b1;
    address = a;
    #1;
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    reset     = 1'b1;
    address   = '0;
    cs        = '0;
    write_n   = 1'b1;
    writedata = '0;
    in0 = '0; in2 = '0; in32 = '0; in1 = '0;

    #2;
    check("rst_out0", 32'(out0), 32'hA5);
    check("rst_irq0", 32'(irq0), 32'h0);
    check("rst_out2", 32'(out2), 32'h0);
    rd(3'd3); check("rst_mask", rd0, 32'h0);
    rd(3'd4); check("rst_ecap", rd0, 32'h0);

    @(negedge clk);
    reset = 1'b0;

    wr(4'b0001, 3'd0, 32'h0F); check("out_data", 32'(out0), 32'h0F);
    wr(4'b0001, 3'd1, 32'hC0); check("out_set",  32'(out0), 32'hCF);
    wr(4'b0001, 3'd2, 32'h03); check("out_clr",  32'(out0), 32'hCC);
    rd(3'd1); check("rd_outset", rd0, 32'hCC);
    rd(3'd0); check("rd_data_in0", rd0, 32'h00);

    wr(4'b0001, 3'd3, 32'h01);
    rd(3'd3); check("rd_mask", rd0, 32'h01);
    @(negedge clk);
    in0 = 8'h01;
    @(negedge clk);
    check("irq_n0", 32'(irq0), 32'h0);
    rd(3'd4); check("ecap_n0", rd0, 32'h0);
    @(negedge clk);
    check("irq_n1", 32'(irq0), 32'h0);
    rd(3'd0); check("sync_n1", rd0, 32'h01);
    @(negedge clk);
    check("irq_n2", 32'(irq0), 32'h1);
    rd(3'd4); check("ecap_n2", rd0, 32'h01);
    @(negedge clk);
    wr(4'b0001, 3'd4, 32'h01);
    check("irq_clr", 32'(irq0), 32'h0);
    rd(3'd4); check("ecap_clr", rd0, 32'h0);

    in0 = 8'h00;
    repeat (4) @(negedge clk);
    check("fall_irq", 32'(irq0), 32'h0);
    rd(3'd4); check("fall_ecap", rd0, 32'h0);

    @(negedge clk);
    in0 = 8'h04;
    @(negedge clk);
    @(negedge clk);
    wr(4'b0001, 3'd4, 32'h04);
    rd(3'd4); check("set_wins", rd0, 32'h04);
    @(negedge clk);
    wr(4'b0001, 3'd4, 32'h04);
    rd(3'd4); check("clr_after", rd0, 32'h0);

    @(negedge clk);
    wr(4'b0001, 3'd6, 32'hFF);
    check("addr6_wr", 32'(out0), 32'hCC);
    rd(3'd6); check("addr6_rd", rd0, 32'h0);

    @(negedge clk);
    in2 = 8'h01;
    repeat (3) @(negedge clk);
    rd(3'd4); check("any_rise", rd2, 32'h01);
    check("any_irq_masked", 32'(irq2), 32'h0);
    @(negedge clk);
    wr(4'b0010, 3'd4, 32'h01);
    rd(3'd4); check("any_clr", rd2, 32'h0);
    in2 = 8'h00;
    repeat (3) @(negedge clk);
    rd(3'd4); check("any_fall", rd2, 32'h01);

    @(negedge clk);
    wr(4'b1100, 3'd0, 32'hFFFF_FFFF);
    check("w32_out", out32, 32'hFFFF_FFFF);
    check("w1_out", 32'(out1), 32'h1);
    rd(3'd1);
    check("w32_rd", rd32, 32'hFFFF_FFFF);
    check("w1_rd", rd1, 32'h0000_0001);
    rd(3'd6); check("w1_addr6", rd1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
